// File: rtl/gearbox56_feed_ctrl.sv
// gearbox56_feed_ctrl
// Feeds a 64->56 bit gearbox from a 64-bit SHAKE squeeze stream. The controller
// accepts words over valid/ready, issues one gearbox load strobe per word, and
// adds an eighth "flush" strobe per group that consumes no word. It counts issued
// strobes and returned samples, and pulses done after NUM_SAMPLES samples.
module gearbox56_feed_ctrl #(
  parameter int NUM_SAMPLES = 512,
  parameter int CNT_W       = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic [63:0]      src_data,
  output logic             gb_rst,
  output logic             gb_inflag,
  output logic [63:0]      gb_din,
  input  logic [55:0]      gb_dout,
  input  logic             gb_dflag,
  output logic             smp_valid,
  output logic [55:0]      smp_data,
  output logic [CNT_W-1:0] smp_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_DRAIN
  } state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_SAMPLES);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] issued_q;
  logic [CNT_W-1:0] returned_q;
  logic [2:0]       phase_q;
  logic             busy_q;
  logic             done_q;
  logic             gb_rst_q;

  logic             flush;
  logic             strobe;
  logic             sample_window;

  // Strobe generation and the sample pass-through are combinational so that a
  // word is handed to the gearbox in the same cycle it is accepted.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    flush         = 1'b0;
    strobe        = 1'b0;
    src_ready     = 1'b0;
    gb_inflag     = 1'b0;
    gb_din        = '0;
    sample_window = 1'b0;
    smp_valid     = 1'b0;
    smp_data      = '0;

    // Strobes stop once the job's quota is issued; an abort kills the cycle's
    // handshake so no word is taken from the source and then dropped.
    if (state_q == S_RUN && issued_q < LAST && !abort) begin
      flush     = (phase_q == 3'd7);
      src_ready = !flush;
      strobe    = flush || src_valid;
      gb_inflag = strobe;
      gb_din    = (strobe && !flush) ? src_data : '0;
    end

    // Samples are only forwarded while a job is live; late flags after an
    // abort or reset are masked.
    sample_window = (state_q == S_RUN) || (state_q == S_DRAIN);
    if (sample_window) begin
      smp_valid = gb_dflag;
      smp_data  = gb_dout;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign gb_rst  = gb_rst_q;
  assign smp_idx = returned_q;

  // Job FSM, strobe/sample counters, gearbox phase and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      issued_q   <= '0;
      returned_q <= '0;
      phase_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      gb_rst_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // updates from the values present before this edge.
      done_q <= 1'b0;

      if (smp_valid && returned_q < LAST) begin
        returned_q <= returned_q + ONE;
      end

      if (state_q != S_IDLE && abort) begin
        state_q  <= S_IDLE;
        busy_q   <= 1'b0;
        gb_rst_q <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            gb_rst_q <= 1'b1;
            if (start) begin
              state_q    <= S_CLR;
              issued_q   <= '0;
              returned_q <= '0;
              phase_q    <= '0;
              busy_q     <= 1'b1;
            end
          end
          S_CLR: begin
            // One cycle of gb_rst has zeroed the gearbox phase and remainder.
            state_q  <= S_RUN;
            gb_rst_q <= 1'b0;
          end
          S_RUN: begin
            if (strobe) begin
              issued_q <= issued_q + ONE;
              phase_q  <= phase_q + 3'd1;
              if (issued_q + ONE == LAST) begin
                state_q <= S_DRAIN;
              end
            end
          end
          S_DRAIN: begin
            if (smp_valid && returned_q + ONE == LAST) begin
              state_q  <= S_IDLE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              gb_rst_q <= 1'b1;
            end
          end
          default: begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            gb_rst_q <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
